// File: rtl/reg_wb_queue.sv
// Pending register-writeback queue: buffers results until the register-file
// write port is free, and exposes the youngest pending value for each read port.
module reg_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_reg,
  input  logic [3:0]                 in_data,
  input  logic                       wb_stall,
  output logic                       regwrite,
  output logic [3:0]                 write_reg,
  output logic [3:0]                 write_data,
  input  logic [3:0]                 byp_reg1,
  input  logic [3:0]                 byp_reg2,
  output logic                       byp_hit1,
  output logic                       byp_hit2,
  output logic [3:0]                 byp_data1,
  output logic [3:0]                 byp_data2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    entry_reg  [DEPTH];
  logic [3:0]    entry_data [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] scan_idx;
  logic          push_fire;
  logic          do_enq;
  logic          do_pop;

  assign empty     = (count == CW'(0));
  assign full      = (count == CW'(DEPTH));
  assign in_ready  = !full;
  assign push_fire = in_valid && in_ready;
  // Writes to r0 complete the handshake but are dropped, since r0 is never written.
  assign do_enq    = push_fire && (in_reg != 4'd0);
  assign do_pop    = !empty && !wb_stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i]  <= 4'd0;
        entry_data[i] <= 4'd0;
      end
    end else begin
      if (do_enq) begin
        entry_reg[tail]  <= in_reg;
        entry_data[tail] <= in_data;
        tail             <= tail + AW'(1);
      end
      if (do_pop) begin
        head <= head + AW'(1);
      end
      case ({do_enq, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      regwrite   <= 1'b0;
      write_reg  <= 4'd0;
      write_data <= 4'd0;
    end else if (do_pop) begin
      regwrite   <= 1'b1;
      write_reg  <= entry_reg[head];
      write_data <= entry_data[head];
    end else begin
      regwrite <= 1'b0;
    end
  end

  // Lowest priority first: output register, then queue oldest-to-youngest,
  // so later matches overwrite earlier ones and the youngest wins.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_data1 = 4'd0;
    byp_hit2  = 1'b0;
    byp_data2 = 4'd0;
    scan_idx  = head;
    if (regwrite && byp_reg1 != 4'd0 && write_reg == byp_reg1) begin
      byp_hit1  = 1'b1;
      byp_data1 = write_data;
    end
    if (regwrite && byp_reg2 != 4'd0 && write_reg == byp_reg2) begin
      byp_hit2  = 1'b1;
      byp_data2 = write_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + AW'(i);
      if (CW'(i) < count) begin
        if (byp_reg1 != 4'd0 && entry_reg[scan_idx] == byp_reg1) begin
          byp_hit1  = 1'b1;
          byp_data1 = entry_data[scan_idx];
        end
        if (byp_reg2 != 4'd0 && entry_reg[scan_idx] == byp_reg2) begin
          byp_hit2  = 1'b1;
          byp_data2 = entry_data[scan_idx];
        end
      end
    end
  end

endmodule
